// File: rtl/rbfu_result_collector_if.sv
// Issue side, RBFU result inputs and coefficient-memory write port of the result collector.
// The collector uses the slave view; the surrounding datapath/memory uses the master view.
interface rbfu_result_collector_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
);
   logic                  issue_valid;
   logic                  issue_ready;
   logic [1:0]            issue_opcode;
   logic [ADDR_WIDTH-1:0] issue_base;
   logic [ADDR_WIDTH-1:0] issue_stride;
   logic [DATA_WIDTH-1:0] Dout0;
   logic [DATA_WIDTH-1:0] Dout1;
   logic [DATA_WIDTH-1:0] Dout2;
   logic [DATA_WIDTH-1:0] Dout3;
   logic                  wr_valid;
   logic                  wr_ready;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_last;
   logic                  idle;

   modport master (
      output issue_valid, issue_opcode, issue_base, issue_stride,
      output Dout0, Dout1, Dout2, Dout3, wr_ready,
      input  issue_ready, wr_valid, wr_addr, wr_data, wr_last, idle
   );

   modport slave (
      input  issue_valid, issue_opcode, issue_base, issue_stride,
      input  Dout0, Dout1, Dout2, Dout3, wr_ready,
      output issue_ready, wr_valid, wr_addr, wr_data, wr_last, idle
   );
endinterface

// File: rtl/rbfu_result_collector.sv
// Tracks RBFU operations through a latency-matched tag line, captures their results into a
// small FIFO and drains them as single-word memory writes, with credit-based issue throttling.
module rbfu_result_collector #(
   parameter int         DATA_WIDTH = 16,
   parameter int         ADDR_WIDTH = 8,
   parameter int         LATENCY    = 3,
   parameter int         DEPTH      = 4,
   parameter logic [1:0] PWM_OP     = 2'b10
) (
   input logic                    clk,
   input logic                    rst,
   rbfu_result_collector_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [LATENCY-1:0]    tag_valid_reg;
   logic [1:0]            tag_op_reg     [LATENCY];
   logic [ADDR_WIDTH-1:0] tag_base_reg   [LATENCY];
   logic [ADDR_WIDTH-1:0] tag_stride_reg [LATENCY];

   logic [DATA_WIDTH-1:0] fifo_data_reg   [DEPTH][4];
   logic [ADDR_WIDTH-1:0] fifo_base_reg   [DEPTH];
   logic [ADDR_WIDTH-1:0] fifo_stride_reg [DEPTH];
   logic                  fifo_pwm_reg    [DEPTH];

   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] occ_reg;
   logic [CW-1:0] inflight_reg;
   logic [1:0]    word_cnt_reg;

   logic                  accept;
   logic                  capture;
   logic                  fifo_nonempty;
   logic                  handshake;
   logic                  pop;
   logic                  last_word;
   logic [DATA_WIDTH-1:0] dout_vec [4];

   assign dout_vec[0] = bus.Dout0;
   assign dout_vec[1] = bus.Dout1;
   assign dout_vec[2] = bus.Dout2;
   assign dout_vec[3] = bus.Dout3;

   assign capture       = tag_valid_reg[LATENCY-1];
   assign accept        = bus.issue_valid & bus.issue_ready;
   assign fifo_nonempty = (occ_reg != '0);
   assign last_word     = (word_cnt_reg == (fifo_pwm_reg[rd_ptr_reg] ? 2'd1 : 2'd3));
   assign handshake     = fifo_nonempty & bus.wr_ready;
   assign pop           = handshake & last_word;

   // Every in-flight tag is guaranteed a FIFO slot, so a capture can never meet a full FIFO.
   assign bus.issue_ready = ({1'b0, inflight_reg} + {1'b0, occ_reg}) < (CW+1)'(DEPTH);
   assign bus.idle        = (inflight_reg == '0) & (occ_reg == '0);

   assign bus.wr_valid = fifo_nonempty;
   assign bus.wr_last  = fifo_nonempty & last_word;
   assign bus.wr_data  = fifo_nonempty ? fifo_data_reg[rd_ptr_reg][word_cnt_reg] : '0;
   assign bus.wr_addr  = fifo_nonempty
                       ? fifo_base_reg[rd_ptr_reg]
                         + ADDR_WIDTH'(word_cnt_reg) * fifo_stride_reg[rd_ptr_reg]
                       : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_valid_reg <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_op_reg[i]     <= '0;
            tag_base_reg[i]   <= '0;
            tag_stride_reg[i] <= '0;
         end
      end else begin
         tag_valid_reg[0]  <= accept;
         tag_op_reg[0]     <= bus.issue_opcode;
         tag_base_reg[0]   <= bus.issue_base;
         tag_stride_reg[0] <= bus.issue_stride;
         for (int i = 1; i < LATENCY; i++) begin
            tag_valid_reg[i]  <= tag_valid_reg[i-1];
            tag_op_reg[i]     <= tag_op_reg[i-1];
            tag_base_reg[i]   <= tag_base_reg[i-1];
            tag_stride_reg[i] <= tag_stride_reg[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_reg <= '0;
         occ_reg      <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         word_cnt_reg <= '0;
      end else begin
         inflight_reg <= inflight_reg + CW'(accept) - CW'(capture);
         occ_reg      <= occ_reg + CW'(capture) - CW'(pop);
         if (capture)
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         if (handshake)
            word_cnt_reg <= last_word ? 2'd0 : word_cnt_reg + 2'd1;
      end
   end

   // Storage only; reads are masked by fifo_nonempty, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int w = 0; w < 4; w++)
            fifo_data_reg[wr_ptr_reg][w] <= dout_vec[w];
         fifo_base_reg[wr_ptr_reg]   <= tag_base_reg[LATENCY-1];
         fifo_stride_reg[wr_ptr_reg] <= tag_stride_reg[LATENCY-1];
         fifo_pwm_reg[wr_ptr_reg]    <= (tag_op_reg[LATENCY-1] == PWM_OP);
      end
   end
endmodule

// File: tb/tb_rbfu_result_collector.sv
// Randomized scoreboard bench for rbfu_result_collector: the bench plays the RBFU and the
// memory, predicts every write from issue parameters and checks credits, order and stability.
module tb_rbfu_result_collector;
   localparam int         DW    = 16;
   localparam int         AW    = 8;
   localparam int         LAT   = 3;
   localparam int         DEPTH = 4;
   localparam logic [1:0] PWM   = 2'b10;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rbfu_result_collector_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   rbfu_result_collector #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(LAT), .DEPTH(DEPTH), .PWM_OP(PWM)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   wr_t           exp_q[$];
   logic [4*DW-1:0] dout_at [int];
   int            cyc = 0;
   int            outstanding = 0;
   int            vectors = 0;
   int            miscompares = 0;
   int            accepted = 0;
   int            writes = 0;
   bit            accept_pending = 0;
   bit            pop_pending = 0;
   bit            stall_prev = 0;
   wr_t           stall_word;

   // Entries accepted but not yet fully written: exactly what the credit check must bound.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst)
         outstanding <= 0;
      else
         outstanding <= outstanding + int'(accept_pending) - int'(pop_pending);
      accept_pending <= 0;
      pop_pending    <= 0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit v, input logic [1:0] op, input logic [AW-1:0] base,
                       input logic [AW-1:0] stride, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic [DW-1:0] d3, input bit rdy);
      int            n;
      logic [DW-1:0] w [4];
      wr_t           e;
      @(negedge clk);
      if (dout_at.exists(cyc)) begin
         {bus.Dout3, bus.Dout2, bus.Dout1, bus.Dout0} = dout_at[cyc];
         dout_at.delete(cyc);
      end else begin
         {bus.Dout3, bus.Dout2, bus.Dout1, bus.Dout0} = {$urandom, $urandom};
      end
      bus.wr_ready     = rdy;
      bus.issue_valid  = v;
      bus.issue_opcode = op;
      bus.issue_base   = base;
      bus.issue_stride = stride;
      if (v && bus.issue_ready && !rst) begin
         w[0] = d0; w[1] = d1; w[2] = d2; w[3] = d3;
         n = (op == PWM) ? 2 : 4;
         for (int k = 0; k < n; k++) begin
            e.addr = AW'((int'(base) + k * int'(stride)) % (1 << AW));
            e.data = w[k];
            e.last = (k == n - 1);
            exp_q.push_back(e);
         end
         dout_at[cyc + LAT] = {d3, d2, d1, d0};
         accept_pending = 1;
         accepted++;
      end
   endtask

   task automatic idle_step(input bit rdy);
      step(0, 2'b00, '0, '0, '0, '0, '0, '0, rdy);
   endtask

   task automatic rand_step(input bit v, input bit rdy);
      step(v, 2'($urandom_range(0, 3)), AW'($urandom), AW'($urandom), DW'($urandom),
           DW'($urandom), DW'($urandom), DW'($urandom), rdy);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || outstanding != 0) && n < budget) begin
         idle_step(1);
         n++;
      end
      check("drain_complete", 64'(exp_q.size() + outstanding), 64'd0);
   endtask

   always @(negedge clk) begin
      wr_t e;
      #3;
      if (rst) begin
         stall_prev = 0;
      end else begin
         check("issue_ready", 64'(bus.issue_ready), 64'(outstanding < DEPTH));
         check("idle", 64'(bus.idle), 64'(outstanding == 0));
         if (stall_prev) begin
            check("stall_valid", 64'(bus.wr_valid), 64'd1);
            check("stall_word", 64'({bus.wr_addr, bus.wr_data, bus.wr_last}), 64'(stall_word));
         end
         if (bus.wr_valid) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL stale_write: got addr %0d data %0h, expected no write",
                        bus.wr_addr, bus.wr_data);
            end else if (bus.wr_ready) begin
               e = exp_q.pop_front();
               check("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
               check("wr_data", 64'(bus.wr_data), 64'(e.data));
               check("wr_last", 64'(bus.wr_last), 64'(e.last));
               $display("write %0d: addr %0d data %0h last %0b", writes, bus.wr_addr,
                        bus.wr_data, bus.wr_last);
               writes++;
               if (e.last)
                  pop_pending = 1;
            end
         end
         stall_prev = bus.wr_valid && !bus.wr_ready;
         stall_word = '{addr: bus.wr_addr, data: bus.wr_data, last: bus.wr_last};
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0;
      int w0;
      int n;
      bus.issue_valid = 0; bus.issue_opcode = '0; bus.issue_base = '0; bus.issue_stride = '0;
      bus.Dout0 = '0; bus.Dout1 = '0; bus.Dout2 = '0; bus.Dout3 = '0; bus.wr_ready = 0;
      repeat (2) @(negedge clk);
      #3;
      check("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
      check("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
      check("rst_wr_data", 64'(bus.wr_data), 64'd0);
      check("rst_wr_last", 64'(bus.wr_last), 64'd0);
      check("rst_idle", 64'(bus.idle), 64'd1);
      check("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
      @(negedge clk);
      rst = 0;

      // Single radix-4 op with first-write latency check.
      step(1, 2'b00, 8'd8, 8'd16, 16'd1, 16'd2, 16'd3, 16'd4, 1);
      for (int i = 0; i < 4; i++) begin
         idle_step(1);
         #3;
         check("first_valid_latency", 64'(bus.wr_valid), 64'(i == 3));
      end
      wait_drain(50);

      step(1, PWM, 8'd5, 8'd1, 16'd100, 16'd200, 16'hdead, 16'hbeef, 1);
      wait_drain(50);

      step(1, 2'b01, 8'd250, 8'd3, 16'h11, 16'h22, 16'h33, 16'h44, 1);
      wait_drain(50);

      // Backpressure: only DEPTH issues may be accepted while nothing drains.
      a0 = accepted;
      for (int i = 0; i < 8; i++)
         step(1, 2'b00, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
              DW'($urandom), DW'($urandom), 0);
      #3;
      check("bp_accepted", 64'(accepted - a0), 64'd4);
      check("bp_issue_ready", 64'(bus.issue_ready), 64'd0);
      wait_drain(100);

      for (int i = 0; i < 24; i++)
         rand_step($urandom_range(0, 3) != 0, (i % 2) == 0);
      wait_drain(200);

      for (int i = 0; i < 300; i++)
         rand_step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      wait_drain(300);

      // Reset while entry 2 of 3 is draining.
      w0 = writes;
      for (int i = 0; i < 3; i++)
         step(1, 2'b00, AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
              DW'($urandom), DW'($urandom), 1);
      n = 0;
      while (writes - w0 < 5 && n < 50) begin
         idle_step(1);
         n++;
      end
      check("reset_test_reached_entry2", 64'(writes - w0 >= 5), 64'd1);
      @(posedge clk);
      #2;
      rst = 1;
      #1;
      check("async_rst_wr_valid", 64'(bus.wr_valid), 64'd0);
      check("async_rst_idle", 64'(bus.idle), 64'd1);
      exp_q.delete();
      dout_at.delete();
      repeat (2) @(negedge clk);
      rst = 0;
      #3;
      check("post_rst_idle", 64'(bus.idle), 64'd1);
      check("post_rst_issue_ready", 64'(bus.issue_ready), 64'd1);
      for (int i = 0; i < 10; i++)
         idle_step(1);

      step(1, PWM, 8'd255, 8'd2, 16'h0aa, 16'h0bb, 16'h0cc, 16'h0dd, 1);
      wait_drain(50);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
